mpu_load_sequencer: RTL

Sequences one matrix load into the MPU register file. Accepts a load command (target register, rows, columns), then consumes a valid/ready stream of `float_sp` elements in row-major order. Each element drives the register file load port at the correct (i, j) location and waits on its `load_ready_out`. Sits between the memory-side load path and the register file load port, and pulses completion or error back to the issuing controller.

---
 rtl/global_defs.sv | 14 +
 rtl/mpu_data_types.sv | 19 +
 rtl/mpu_load_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/global_defs.sv
// Shared MPU sizing constants: matrix dimensions, index widths, register file depth.
package global_defs;

    // Maximum matrix rows and columns held by one matrix register.
    localparam int unsigned M = 4;
    localparam int unsigned N = 4;

    // Index MSBs; fields are [MBITS:0], [NBITS:0] and [MATRIX_REG_BITS:0] so that
    // a size equal to M or N is representable.
    localparam int unsigned MBITS           = 2;
    localparam int unsigned NBITS           = 2;
    localparam int unsigned MATRIX_REG_BITS = 2;

endpackage : global_defs

// File: rtl/mpu_data_types.sv
// MPU datapath element type and load sequencer state encoding.
package mpu_data_types;

    // IEEE-754 single-precision element as carried on MPU buses.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_sp;

    // Matrix load sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } load_seq_state_t;

endpackage : mpu_data_types

// File: rtl/mpu_load_sequencer.sv
// Sequences one matrix load: accepts a (reg, rows, cols) command, then forwards a
// row-major element stream to the register file load port with (i, j) locations.
module mpu_load_sequencer
    import global_defs::*;
    import mpu_data_types::*;
(
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       cmd_valid_in,
    output logic                       cmd_ready_out,
    input  logic [MATRIX_REG_BITS:0]   cmd_addr_in,
    input  logic [MBITS:0]             cmd_m_in,
    input  logic [NBITS:0]             cmd_n_in,

    input  logic                       elem_valid_in,
    output logic                       elem_ready_out,
    input  float_sp                    elem_data_in,

    output logic                       reg_load_req_out,
    input  logic                       load_ready_in,
    output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out,
    output float_sp                    reg_load_element_out,

    output logic                       busy_out,
    output logic                       done_out,
    output logic                       error_out
);

    localparam int unsigned MW = MBITS + 1;
    localparam int unsigned NW = NBITS + 1;
    localparam int unsigned AW = MATRIX_REG_BITS + 1;

    load_seq_state_t   state_q;
    logic [AW-1:0]     addr_q;
    logic [MW-1:0]     m_q;
    logic [NW-1:0]     n_q;
    logic [MW-1:0]     i_q;
    logic [NW-1:0]     j_q;

    logic              cmd_bad_c;
    logic              xfer_c;
    logic              last_col_c;
    logic              last_row_c;

    // Command legality: empty or oversize matrices are rejected without touching the register file.
    always_comb begin
        cmd_bad_c = 1'b0;
        if ((cmd_m_in == '0) || (cmd_n_in == '0) ||
            (cmd_m_in > MW'(M)) || (cmd_n_in > NW'(N))) begin
            cmd_bad_c = 1'b1;
        end
    end

    // Element handshake and end-of-row / end-of-matrix detection at port width.
    always_comb begin
        xfer_c     = (state_q == STREAM) && elem_valid_in && load_ready_in;
        last_col_c = (j_q == (n_q - NW'(1)));
        last_row_c = (i_q == (m_q - MW'(1)));
    end

    // Sequencer state, latched command and row-major location counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            m_q     <= '0;
            n_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_in) begin
                        if (cmd_bad_c) begin
                            state_q <= ERR;
                        end else begin
                            state_q <= STREAM;
                            addr_q  <= cmd_addr_in;
                            m_q     <= cmd_m_in;
                            n_q     <= cmd_n_in;
                            i_q     <= '0;
                            j_q     <= '0;
                        end
                    end
                end
                STREAM: begin
                    if (xfer_c) begin
                        // Final element leaves the counters at (m-1, n-1) so they never overrun.
                        if (last_col_c && last_row_c) begin
                            state_q <= DONE;
                        end else if (last_col_c) begin
                            j_q <= '0;
                            i_q <= i_q + MW'(1);
                        end else begin
                            j_q <= j_q + NW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status and handshake outputs decoded from the state register.
    assign cmd_ready_out = (state_q == IDLE);
    assign busy_out      = (state_q != IDLE);
    assign done_out      = (state_q == DONE);
    assign error_out     = (state_q == ERR);

    // Stream handshake is only open in STREAM; data passes straight through.
    assign elem_ready_out       = (state_q == STREAM) && load_ready_in;
    assign reg_load_req_out     = (state_q == STREAM) && elem_valid_in;
    assign reg_load_element_out = elem_data_in;

    // Register file location, address and size come from registered state.
    assign reg_load_addr_out   = addr_q;
    assign reg_i_load_loc_out  = i_q;
    assign reg_j_load_loc_out  = j_q;
    assign reg_m_load_size_out = m_q;
    assign reg_n_load_size_out = n_q;

endmodule : mpu_load_sequencer
